// File: rtl/pb_port_hub.sv
// rtl/pb_port_hub.sv - registered kcpsm3 port hub: read mux, output latches, access pulses, sticky error
module pb_port_hub #(
  parameter int               WIDTH       = 8,
  parameter int               N_IN        = 4,
  parameter int               N_OUT       = 4,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             port_id,
  input  logic                   read_strobe,
  input  logic                   write_strobe,
  input  logic [WIDTH-1:0]       out_port,
  output logic [WIDTH-1:0]       in_port,
  input  logic [N_IN*WIDTH-1:0]  chan_in,
  output logic [N_IN-1:0]        rd_pulse,
  output logic [N_OUT*WIDTH-1:0] chan_out,
  output logic [N_OUT-1:0]       wr_pulse,
  output logic                   err,
  input  logic                   clr_err
);

  localparam int N_MAX = (N_IN > N_OUT) ? N_IN : N_OUT;
  localparam int SEL_W = $clog2(N_MAX);

  logic [SEL_W-1:0]            idx;
  logic                        rd_ok;
  logic                        wr_ok;
  logic [N_IN-1:0][WIDTH-1:0]  chan_q;
  logic [N_OUT-1:0][WIDTH-1:0] out_q;
  logic [WIDTH-1:0]            rd_data;
  logic [N_IN-1:0]             rd_dec;
  logic [N_OUT-1:0]            wr_dec;
  logic                        err_set;
  logic                        unused_port_bits;

  // Upper port_id bits are don't-care; the hub only decodes the low SEL_W bits.
  assign idx              = port_id[SEL_W-1:0];
  assign unused_port_bits = ^port_id[7:SEL_W];
  assign rd_ok            = (int'(idx) < N_IN);
  assign wr_ok            = (int'(idx) < N_OUT);
  assign chan_out         = out_q;

  always_comb begin
    rd_data = DEFAULT_VAL;
    rd_dec  = '0;
    wr_dec  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx == SEL_W'(i)) begin
        rd_data   = chan_q[i];
        rd_dec[i] = read_strobe;
      end
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (idx == SEL_W'(k)) begin
        wr_dec[k] = write_strobe;
      end
    end
  end

  assign err_set = (read_strobe && !rd_ok) || (write_strobe && !wr_ok);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_port  <= DEFAULT_VAL;
      chan_q   <= '0;
      out_q    <= '0;
      rd_pulse <= '0;
      wr_pulse <= '0;
      err      <= 1'b0;
    end else begin
      chan_q   <= chan_in;
      in_port  <= rd_data;
      rd_pulse <= rd_dec;
      wr_pulse <= wr_dec;
      for (int k = 0; k < N_OUT; k++) begin
        if (wr_dec[k]) begin
          out_q[k] <= out_port;
        end
      end
      // A new error event in the same cycle as clr_err keeps the flag set.
      if (err_set) begin
        err <= 1'b1;
      end else if (clr_err) begin
        err <= 1'b0;
      end
    end
  end

endmodule
